d_latch_bank: RTL
=================

D_LATCH_BANK -- requirements
Module: d_latch_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent channels.
REQ-003 SHALL have parameter CNT_W, default 8, width of each per-channel load counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port E, input, CHANNELS, per-channel enable.
REQ-007 SHALL have port D, input, CHANNELS*WIDTH, per-channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port MODE, input, 2*CHANNELS, per-channel mode; channel i occupies bits [2*i +: 2].
REQ-009 SHALL have port FREEZE, input, 1, global hold; blocks all loads.
REQ-010 SHALL have port CLR_CNT, input, 1, synchronous clear of all load counters.
REQ-011 SHALL have port Q, output, CHANNELS*WIDTH, registered per-channel data, packed like D.
REQ-012 SHALL have port UPD, output, CHANNELS, one-cycle pulse per channel, coincident with the Q update for that load.
REQ-013 SHALL have port CNT, output, CHANNELS*CNT_W, per-channel saturating load count.

Function
REQ-014 SHALL keep a registered copy e_prev[i] of E[i] per channel; it updates every cycle regardless of MODE or FREEZE.
REQ-015 SHALL decode MODE as follows: 00 FOLLOW, 01 RISE, 10 FALL, 11 TOGGLE.
REQ-016 SHALL define a load for FOLLOW as every cycle with E[i]=1; Q[i] <= D[i] at the next edge, so Q lags D by 1 cycle while E is high.
REQ-017 SHALL define a load for RISE as E[i]=1 with e_prev[i]=0; Q[i] <= D[i].
REQ-018 SHALL define a load for FALL as E[i]=0 with e_prev[i]=1; Q[i] <= D[i].
REQ-019 SHALL define a load for TOGGLE as E[i]=1 with e_prev[i]=0; Q[i] <= Q[i] ^ D[i].
REQ-020 SHALL hold Q[i] in all cycles without a load.
REQ-021 SHALL suppress every load while FREEZE=1, holding Q, UPD and CNT; edges occurring during FREEZE are lost, not deferred.
REQ-022 SHALL set UPD[i]=1 for exactly the cycle after a load is detected, even if the new Q equals the old Q; otherwise UPD[i]=0.
REQ-023 SHALL increment CNT[i] by 1 per load and saturate at 2^CNT_W-1; it never wraps.
REQ-024 SHALL give priority to CLR_CNT over a simultaneous load, so CNT becomes 0; Q and UPD still follow the load.
REQ-025 SHALL apply a MODE change in the same cycle it is presented, with no flush; e_prev history carries across the change.
REQ-026 SHALL keep channels fully independent; one channel's activity never affects another.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, force Q=0, UPD=0, CNT=0 and e_prev=0, overriding FREEZE, CLR_CNT and any load.
REQ-028 SHALL treat E[i]=1 in the first cycle after reset as a rising edge because e_prev=0.

Structure
REQ-029 SHALL place the 2-bit mode encoding constants (FOLLOW, RISE, FALL, TOGGLE) in shared package d_latch_pkg.
REQ-030 SHALL implement one channel (e_prev, Q, UPD, CNT) as sub-module d_latch_chan, instantiated CHANNELS times by a generate loop.

Verification
REQ-031 SHALL cover FOLLOW on channel 0 with D=8'hA5 and E high for 3 cycles: Q=8'hA5 one cycle after E rises, UPD=1 for 3 cycles, CNT=3.
REQ-032 SHALL cover RISE on channel 1 with E toggling every 3 cycles and D changing every 5 (D=0x01, 0x02, ...): Q loads D only on the cycle after each E rise, and CNT equals the rise count.
REQ-033 SHALL cover TOGGLE on channel 2 with Q=0 and D=8'h0F over two E rising edges: Q=8'h0F, then 8'h00, with UPD pulsing both times.
REQ-034 SHALL cover FREEZE=1 across an E rise in RISE mode: Q, CNT and UPD remain unchanged; after FREEZE drops with E still high, there is no load.
REQ-035 SHALL cover CNT_W=2 with 5 loads: CNT reaches 3 and stays there; CLR_CNT asserted together with a load gives CNT=0 while Q still updates.
REQ-036 SHALL cover rst asserted mid-stream with E=1 held through release: all outputs 0 while rst is high, and a load on the first post-reset cycle (RISE mode), giving CNT=1.

Source files
------------

// File: rtl/d_latch_pkg.sv
// rtl/d_latch_pkg.sv - shared mode encodings for the d_latch bank
package d_latch_pkg;

  localparam logic [1:0] MODE_FOLLOW = 2'b00;
  localparam logic [1:0] MODE_RISE   = 2'b01;
  localparam logic [1:0] MODE_FALL   = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

endpackage

// File: rtl/d_latch_chan.sv
// rtl/d_latch_chan.sv - one channel: enable edge history, data register, update pulse, load counter
module d_latch_chan
  import d_latch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             freeze,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic             upd,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             e_prev;
  logic             e_rise;
  logic             e_fall;
  logic             load;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    e_rise = e & ~e_prev;
    e_fall = ~e & e_prev;
    load   = 1'b0;
    q_next = d;
    case (mode)
      MODE_FOLLOW: load = e;
      MODE_RISE:   load = e_rise;
      MODE_FALL:   load = e_fall;
      MODE_TOGGLE: begin
        load   = e_rise;
        q_next = q ^ d;
      end
      default:     load = 1'b0;
    endcase
    // edges seen while frozen are dropped, not remembered
    if (freeze) load = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_prev <= 1'b0;
      q      <= '0;
      upd    <= 1'b0;
      cnt    <= '0;
    end else begin
      e_prev <= e;
      upd    <= load;
      if (load) q <= q_next;
      if (clr_cnt)
        cnt <= '0;
      else if (load && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/d_latch_bank.sv
// rtl/d_latch_bank.sv - bank of independent edge/level loaded data registers
module d_latch_bank
  import d_latch_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       E,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [2*CHANNELS-1:0]     MODE,
  input  logic                      FREEZE,
  input  logic                      CLR_CNT,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       UPD,
  output logic [CHANNELS*CNT_W-1:0] CNT
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    d_latch_chan #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .e       (E[i]),
      .d       (D[i*WIDTH +: WIDTH]),
      .mode    (MODE[2*i +: 2]),
      .freeze  (FREEZE),
      .clr_cnt (CLR_CNT),
      .q       (Q[i*WIDTH +: WIDTH]),
      .upd     (UPD[i]),
      .cnt     (CNT[i*CNT_W +: CNT_W])
    );
  end

endmodule
